// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
//   state_t  : FSM state encoding (visible on the debug state port)
//   OP_*     : opcode field values decoded in DECODE
//   ALU_*, SRCB_*, PCSRC_* : datapath mux/ALU encodings
//   ctrl_t   : bundle of all Moore-decoded datapath controls
//   decode_next() : DECODE-state dispatch on the opcode
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_BNE    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       branch_ne;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    // Disabled optional opcodes fall through to the trap state.
    function automatic logic [3:0] decode_next(input logic [5:0] op,
                                               input bit en_addi,
                                               input bit en_bne);
        case (op)
            OP_RTYPE:     return S_EXEC;
            OP_LW, OP_SW: return S_MEMADR;
            OP_BEQ:       return S_BEQ;
            OP_J:         return S_JUMP;
            OP_ADDI:      return en_addi ? S_ADDIEX : S_TRAP;
            OP_BNE:       return en_bne ? S_BNE : S_TRAP;
            default:      return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> datapath control decode.
//   state     : current FSM state (4 bits, includes unused codes 14/15)
//   mem_ready : effective memory-ready (gates IR/PC write in FETCH)
//   ctrl      : all datapath controls; unlisted controls are 0
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // PC+4 and IR load only commit on the cycle the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_BEQ, S_BNE: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (state == S_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ; // TRAP and unused encodings drive nothing
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control unit: owns the state register, next-state logic,
// sticky illegal-opcode flag and retired-instruction counter.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   op              : IR[31:26], stable while in DECODE/MEMADR
//   mem_ready       : memory access completes this cycle
//   PCWrite..PCSource : Moore-decoded datapath controls
//   state           : current state (debug)
//   illegal_op      : sticky, set on leaving TRAP (or 14/15), cleared by reset
//   instr_count     : retired instructions, wraps at 2^CNT_W
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_BNE  = 1'b1,
    parameter bit MEM_WAIT    = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             BranchNe,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0] st;
    logic       rdy;
    ctrl_t      ctrl;

    assign rdy = MEM_WAIT ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_FETCH;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            case (st)
                S_FETCH:  if (rdy) st <= S_DECODE;
                S_DECODE: st <= decode_next(op, ENABLE_ADDI, ENABLE_BNE);
                S_MEMADR: st <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (rdy) st <= S_MEMWB;
                S_MEMWR: if (rdy) begin
                    st          <= S_FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                S_EXEC:   st <= S_ALUWB;
                S_ADDIEX: st <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_BNE, S_JUMP: begin
                    st          <= S_FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                // TRAP and unreachable codes 14/15: recover, flag, don't retire
                default: begin
                    st         <= S_FETCH;
                    illegal_op <= 1'b1;
                end
            endcase
        end
    end

    mc_ctrl_decode u_dec (
        .state     (st),
        .mem_ready (rdy),
        .ctrl      (ctrl)
    );

    // Write enables are held off while reset is asserted so an abandoned
    // instruction cannot touch architectural state.
    assign PCWrite     = ctrl.pc_write      & ~reset;
    assign PCWriteCond = ctrl.pc_write_cond & ~reset;
    assign MemWrite    = ctrl.mem_write     & ~reset;
    assign IRWrite     = ctrl.ir_write      & ~reset;
    assign RegWrite    = ctrl.reg_write     & ~reset;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegDst      = ctrl.reg_dst;
    assign BranchNe    = ctrl.branch_ne;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign state       = st;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic rst_a, mr_a;
    logic [5:0] op_a;
    logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_srca, a_rw, a_rdst, a_bne;
    logic [1:0] a_aluop, a_srcb, a_pcsrc;
    logic [3:0] a_st;
    logic a_ill;
    logic [15:0] a_cnt;

    // DUT B: addi/bne disabled, mem_ready ignored, 2-bit counter
    logic rst_b, mr_b;
    logic [5:0] op_b;
    logic b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_srca, b_rw, b_rdst, b_bne;
    logic [1:0] b_aluop, b_srcb, b_pcsrc;
    logic [3:0] b_st;
    logic b_ill;
    logic [1:0] b_cnt;

    multicycle_ctrl_fsm u_a (
        .clk(clk), .reset(rst_a), .op(op_a), .mem_ready(mr_a),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
        .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r), .ALUSrcA(a_srca),
        .RegWrite(a_rw), .RegDst(a_rdst), .BranchNe(a_bne), .ALUOp(a_aluop),
        .ALUSrcB(a_srcb), .PCSource(a_pcsrc), .state(a_st), .illegal_op(a_ill),
        .instr_count(a_cnt)
    );

    multicycle_ctrl_fsm #(.ENABLE_ADDI(1'b0), .ENABLE_BNE(1'b0), .MEM_WAIT(1'b0), .CNT_W(2)) u_b (
        .clk(clk), .reset(rst_b), .op(op_b), .mem_ready(mr_b),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
        .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r), .ALUSrcA(b_srca),
        .RegWrite(b_rw), .RegDst(b_rdst), .BranchNe(b_bne), .ALUOp(b_aluop),
        .ALUSrcB(b_srcb), .PCSource(b_pcsrc), .state(b_st), .illegal_op(b_ill),
        .instr_count(b_cnt)
    );

    ctrl_t obs_a, obs_b;
    assign obs_a = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_srca, a_rw, a_rdst, a_bne,
                    a_aluop, a_srcb, a_pcsrc};
    assign obs_b = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_srca, b_rw, b_rdst, b_bne,
                    b_aluop, b_srcb, b_pcsrc};
    logic [4:0] wen_a, wen_b;
    assign wen_a = {a_pcw, a_pcwc, a_mwr, a_irw, a_rw};
    assign wen_b = {b_pcw, b_pcwc, b_mwr, b_irw, b_rw};

    int n_chk = 0, n_pass = 0;
    int m_cnt;   // model: retired instructions on DUT A
    bit m_ill;   // model: sticky illegal flag on DUT A
    int mw_cyc;  // cycles with MemWrite seen on DUT A
    int sq[$];   // expected state per cycle
    logic mq[$]; // mem_ready to drive per cycle

    typedef struct {
        logic [5:0] op;
        int         fw;      // mem_ready=0 cycles in FETCH
        int         mw;      // mem_ready=0 cycles in MEMRD/MEMWR
        int         cycles;  // expected cycles FETCH..back to FETCH
        bit         legal;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    // Control table written straight from the per-state output list.
    function automatic ctrl_t ref_ctrl(input int s, input logic mr);
        ctrl_t c = '0;
        case (s)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            1:  c.alu_src_b = 2'b11;
            2, 10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1; c.iord = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            5:  begin c.mem_write = 1; c.iord = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            11: c.reg_write = 1;
            8, 12: begin
                c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                c.pc_source = 2'b01; c.branch_ne = (s == 12);
            end
            9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit is_legal_a(input logic [5:0] o);
        return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 ||
               o == 6'b000010 || o == 6'b001000 || o == 6'b000101;
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic void add(input int s, input logic m);
        sq.push_back(s);
        mq.push_back(m);
    endfunction

    // One cycle on DUT A: drive mem_ready, sample mid-cycle, advance.
    task automatic step_a(input logic mr, input int exp_st, input string tag);
        mr_a = mr;
        @(negedge clk);
        chk({tag, " state"}, 32'(a_st), 32'(exp_st));
        chk({tag, " ctrl"}, 32'(obs_a), 32'(ref_ctrl(exp_st, mr)));
        if (a_mwr) mw_cyc++;
        @(posedge clk); #1;
    endtask

    // Build the cycle-by-cycle trace of one instruction from its opcode and
    // wait counts, then drive and check it.
    task automatic run_instr_a(input logic [5:0] opc, input int fw, input int mw, input string tag);
        bit legal;
        legal = is_legal_a(opc);
        chk({tag, " count"}, 32'(a_cnt), 32'(m_cnt[15:0]));
        chk({tag, " illegal"}, 32'(a_ill), 32'(m_ill));
        sq.delete();
        mq.delete();
        op_a = opc;
        repeat (fw) add(0, 1'b0);
        add(0, 1'b1);
        add(1, rbit());
        case (opc)
            6'b100011: begin
                add(2, rbit()); repeat (mw) add(3, 1'b0); add(3, 1'b1); add(4, rbit());
            end
            6'b101011: begin
                add(2, rbit()); repeat (mw) add(5, 1'b0); add(5, 1'b1);
            end
            6'b000000: begin add(6, rbit()); add(7, rbit()); end
            6'b000100: add(8, rbit());
            6'b000010: add(9, rbit());
            6'b001000: begin add(10, rbit()); add(11, rbit()); end
            6'b000101: add(12, rbit());
            default:   add(13, rbit());
        endcase
        foreach (sq[i]) step_a(mq[i], sq[i], $sformatf("%s c%0d", tag, i));
        if (legal) m_cnt++;
        else m_ill = 1'b1;
    endtask

    // Run one instruction reactively and count cycles until FETCH reappears.
    task automatic measure_a(input vec_t v, input int idx);
        int cyc = 0;
        int fl = v.fw;
        int ml = v.mw;
        bit left = 0;
        bit done = 0;
        logic [15:0] c0;
        c0 = a_cnt;
        op_a = v.op;
        while (!done && cyc < 40) begin
            if (a_st != 4'd0) left = 1;
            if (left && a_st == 4'd0) done = 1;
            else begin
                if (a_st == 4'd0) begin mr_a = (fl == 0); if (fl > 0) fl--; end
                else if (a_st == 4'd3 || a_st == 4'd5) begin mr_a = (ml == 0); if (ml > 0) ml--; end
                else mr_a = rbit();
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk($sformatf("tbl%0d op=%b cycles", idx, v.op), 32'(cyc), 32'(v.cycles));
        chk($sformatf("tbl%0d count delta", idx), 32'(a_cnt - c0), 32'(v.legal));
        if (v.legal) m_cnt++;
        else m_ill = 1'b1;
        chk($sformatf("tbl%0d illegal", idx), 32'(a_ill), 32'(m_ill));
    endtask

    // One cycle on DUT B; mem_ready held low, which this build ignores.
    task automatic step_b(input logic [5:0] opc, input int exp_st, input string tag);
        op_b = opc;
        mr_b = 1'b0;
        @(negedge clk);
        chk({tag, " state"}, 32'(b_st), 32'(exp_st));
        chk({tag, " ctrl"}, 32'(obs_b), 32'(ref_ctrl(exp_st, 1'b1)));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[11];
        logic [5:0] opl [0:6];
        logic [5:0] ro;

        tbl[0]  = '{6'b100011, 0, 0, 5, 1'b1};
        tbl[1]  = '{6'b101011, 0, 0, 4, 1'b1};
        tbl[2]  = '{6'b000000, 0, 0, 4, 1'b1};
        tbl[3]  = '{6'b000100, 0, 0, 3, 1'b1};
        tbl[4]  = '{6'b000010, 0, 0, 3, 1'b1};
        tbl[5]  = '{6'b001000, 0, 0, 4, 1'b1};
        tbl[6]  = '{6'b000101, 0, 0, 3, 1'b1};
        tbl[7]  = '{6'b100011, 2, 1, 8, 1'b1};
        tbl[8]  = '{6'b101011, 0, 3, 7, 1'b1};
        tbl[9]  = '{6'b000000, 1, 0, 5, 1'b1};
        tbl[10] = '{6'b111111, 0, 0, 3, 1'b0};
        opl = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000101};

        rst_a = 1; rst_b = 1; op_a = '0; op_b = '0; mr_a = 1; mr_b = 0;
        m_cnt = 0; m_ill = 0; mw_cyc = 0;
        @(posedge clk); #1;

        // reset held two more cycles: FETCH with write enables suppressed
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d state", i), 32'(a_st), 32'd0);
            chk($sformatf("rst%0d wen", i), 32'(wen_a), 32'd0);
            chk($sformatf("rst%0d count", i), 32'(a_cnt), 32'd0);
            chk($sformatf("rst%0d illegal", i), 32'(a_ill), 32'd0);
            @(posedge clk); #1;
        end
        rst_a = 0;

        // first FETCH after release is checked by the lw trace
        run_instr_a(6'b100011, 0, 0, "lw");
        chk("lw count", 32'(a_cnt), 32'd1);

        mw_cyc = 0;
        run_instr_a(6'b101011, 0, 3, "sw_wait");
        chk("sw MemWrite cycles", 32'(mw_cyc), 32'd4);
        chk("sw count", 32'(a_cnt), 32'd2);

        run_instr_a(6'b000000, 0, 0, "rtype");
        run_instr_a(6'b000100, 0, 0, "beq");
        chk("rtype+beq count", 32'(a_cnt), 32'd4);
        run_instr_a(6'b000101, 0, 0, "bne_en");
        run_instr_a(6'b001000, 1, 0, "addi");

        for (int i = 0; i < 11; i++) measure_a(tbl[i], i);

        for (int i = 0; i < 80; i++) begin
            int k;
            k = int'($urandom_range(0, 7));
            ro = (k == 7) ? 6'($urandom) : opl[k];
            run_instr_a(ro, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        $sformatf("rnd%0d", i));
        end
        chk("rnd final count", 32'(a_cnt), 32'(m_cnt[15:0]));
        chk("rnd final illegal", 32'(a_ill), 32'(m_ill));

        // DUT B: gating, sticky flag, counter wrap, reset mid-instruction
        rst_a = 1;
        @(posedge clk); #1;
        rst_b = 0;
        chk("b reset count", 32'(b_cnt), 32'd0);
        chk("b reset illegal", 32'(b_ill), 32'd0);
        step_b(6'b000101, 0, "b_bne0");
        step_b(6'b000101, 1, "b_bne1");
        step_b(6'b000101, 13, "b_bne2");
        chk("b bne trap illegal", 32'(b_ill), 32'd1);
        chk("b bne trap count", 32'(b_cnt), 32'd0);
        step_b(6'b001000, 0, "b_addi0");
        step_b(6'b001000, 1, "b_addi1");
        step_b(6'b001000, 13, "b_addi2");
        for (int i = 0; i < 5; i++) begin
            step_b(6'b000010, 0, $sformatf("b_j%0d f", i));
            step_b(6'b000010, 1, $sformatf("b_j%0d d", i));
            step_b(6'b000010, 9, $sformatf("b_j%0d x", i));
        end
        chk("b wrap count", 32'(b_cnt), 32'd1);
        chk("b illegal sticky", 32'(b_ill), 32'd1);
        step_b(6'b100011, 0, "b_lw0");
        step_b(6'b100011, 1, "b_lw1");
        step_b(6'b100011, 2, "b_lw2");
        rst_b = 1;
        @(negedge clk);
        chk("b memrd state", 32'(b_st), 32'd3);
        chk("b memrd wen in reset", 32'(wen_b), 32'd0);
        @(posedge clk); #1;
        chk("b midop reset state", 32'(b_st), 32'd0);
        chk("b midop reset count", 32'(b_cnt), 32'd0);
        chk("b midop reset illegal", 32'(b_ill), 32'd0);
        rst_b = 0;
        step_b(6'b100011, 0, "b_lwf0");
        step_b(6'b100011, 1, "b_lwf1");
        step_b(6'b100011, 2, "b_lwf2");
        step_b(6'b100011, 3, "b_lwf3");
        step_b(6'b100011, 4, "b_lwf4");
        chk("b lw end state", 32'(b_st), 32'd0);
        chk("b lw count", 32'(b_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
